// File: rtl/cachebusarb_pkg.sv
// Shared types for the cache bus arbiter and the bus FSMs that reuse its beat counter.
package cachebusarb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_I = 2'b01,
      GRANT_D = 2'b10
   } arbstate_t;

   function automatic logic rw_active(input logic [1:0] rw);
      return |rw;
   endfunction

endpackage

// File: rtl/cachebusarb_beatcounter.sv
// Beat counter for line bursts: clear has priority over enable, tc flags the last beat.
module beatcounter #(
   parameter int LOGBWPL = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               en,
   output logic [LOGBWPL-1:0] count,
   output logic               tc
);

   logic [LOGBWPL-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)   count_d = '0;
      else if (en) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;
   assign tc    = &count_q;

endmodule

// File: rtl/cachebusarb.sv
// Round-robin arbiter and line-burst sequencer sharing one bus engine between I$ and D$.
module cachebusarb
   import cachebusarb_pkg::*;
#(
   parameter int PA_BITS = 34,
   parameter int AHBW    = 64,
   parameter int LINELEN = 512,
   parameter int LOGBWPL = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         ICacheBusRW,
   input  logic [PA_BITS-1:0] ICacheBusAdr,
   input  logic [1:0]         DCacheBusRW,
   input  logic [PA_BITS-1:0] DCacheBusAdr,
   input  logic               BusReady,
   output logic               BusReq,
   output logic               BusWrite,
   output logic [PA_BITS-1:0] BusAdr,
   output logic [LOGBWPL-1:0] BeatCount,
   output logic               ICacheBusAck,
   output logic               DCacheBusAck,
   output logic               IBeatValid,
   output logic               DBeatValid,
   output logic               BusCommitted
);

   localparam int OFS = $clog2(AHBW / 8);

   arbstate_t          state_q, state_d;
   logic               op_write_q, op_write_d;
   logic               last_d_q, last_d_d;
   logic               committed_q, committed_d;
   logic               gnt_i, gnt_d, granted;
   logic [1:0]         gnt_rw;
   logic [PA_BITS-1:0] gnt_adr;
   logic               abort, done, beat_en, beat_tc;
   logic [LOGBWPL-1:0] beat;
   logic               unused_ok;

   // Selection is driven only by the registered grant; IDLE falls through to the I$ leg.
   always_comb begin
      gnt_i   = (state_q == GRANT_I);
      gnt_d   = (state_q == GRANT_D);
      granted = gnt_i | gnt_d;
      gnt_rw  = gnt_d ? DCacheBusRW  : ICacheBusRW;
      gnt_adr = gnt_d ? DCacheBusAdr : ICacheBusAdr;
      abort   = granted & ~rw_active(gnt_rw) & ~committed_q;
      beat_en = granted & BusReady & ~abort;
      done    = beat_en & beat_tc;
   end

   beatcounter #(.LOGBWPL(LOGBWPL)) u_beatcounter (
      .clk   (clk),
      .reset (reset),
      .clear (done),
      .en    (beat_en),
      .count (beat),
      .tc    (beat_tc)
   );

   always_comb begin
      state_d     = state_q;
      op_write_d  = op_write_q;
      last_d_d    = last_d_q;
      committed_d = committed_q;
      case (state_q)
         IDLE: begin
            committed_d = 1'b0;
            // On a tie the requester not served last wins; writeback beats fetch within a request.
            if (rw_active(DCacheBusRW) && (!rw_active(ICacheBusRW) || !last_d_q)) begin
               state_d    = GRANT_D;
               op_write_d = DCacheBusRW[0];
            end else if (rw_active(ICacheBusRW)) begin
               state_d    = GRANT_I;
               op_write_d = ICacheBusRW[0];
            end
         end
         default: begin
            if (abort) begin
               state_d     = IDLE;
               committed_d = 1'b0;
            end else if (done) begin
               state_d     = IDLE;
               last_d_d    = gnt_d;
               committed_d = 1'b0;
            end else if (BusReady) begin
               committed_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_write_q  <= 1'b0;
         last_d_q    <= 1'b0;
         committed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_write_q  <= op_write_d;
         last_d_q    <= last_d_d;
         committed_q <= committed_d;
      end
   end

   assign BusReq       = granted;
   assign BusWrite     = granted & op_write_q;
   assign BusAdr       = {gnt_adr[PA_BITS-1:LOGBWPL+OFS], beat, {OFS{1'b0}}};
   assign BeatCount    = beat;
   assign ICacheBusAck = gnt_i & done;
   assign DCacheBusAck = gnt_d & done;
   assign IBeatValid   = BusReady & gnt_i & ~op_write_q;
   assign DBeatValid   = BusReady & gnt_d;
   assign BusCommitted = committed_q;

   assign unused_ok = ^{gnt_adr[LOGBWPL+OFS-1:0], ((LINELEN / AHBW) == (2 ** LOGBWPL))};

endmodule

// File: tb/tb_cachebusarb.sv
// Directed bench for cachebusarb: single bursts, round-robin ties, abort, late drop and mid-burst reset.
module tb_cachebusarb;

   localparam int PA_BITS = 34;
   localparam int AHBW    = 64;
   localparam int LINELEN = 512;
   localparam int LOGBWPL = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         ICacheBusRW, DCacheBusRW;
   logic [PA_BITS-1:0] ICacheBusAdr, DCacheBusAdr;
   logic               BusReady;
   logic               BusReq, BusWrite;
   logic [PA_BITS-1:0] BusAdr;
   logic [LOGBWPL-1:0] BeatCount;
   logic               ICacheBusAck, DCacheBusAck, IBeatValid, DBeatValid, BusCommitted;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cachebusarb #(
      .PA_BITS(PA_BITS), .AHBW(AHBW), .LINELEN(LINELEN), .LOGBWPL(LOGBWPL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ICacheBusRW  (ICacheBusRW),
      .ICacheBusAdr (ICacheBusAdr),
      .DCacheBusRW  (DCacheBusRW),
      .DCacheBusAdr (DCacheBusAdr),
      .BusReady     (BusReady),
      .BusReq       (BusReq),
      .BusWrite     (BusWrite),
      .BusAdr       (BusAdr),
      .BeatCount    (BeatCount),
      .ICacheBusAck (ICacheBusAck),
      .DCacheBusAck (DCacheBusAck),
      .IBeatValid   (IBeatValid),
      .DBeatValid   (DBeatValid),
      .BusCommitted (BusCommitted)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rw(input bit is_d, input logic [1:0] rw);
      if (is_d) DCacheBusRW = rw;
      else      ICacheBusRW = rw;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busreq"},    64'(BusReq),       64'd0);
      chk({tag, "_buswrite"},  64'(BusWrite),     64'd0);
      chk({tag, "_beatcount"}, 64'(BeatCount),    64'd0);
      chk({tag, "_iack"},      64'(ICacheBusAck), 64'd0);
      chk({tag, "_dack"},      64'(DCacheBusAck), 64'd0);
      chk({tag, "_ibv"},       64'(IBeatValid),   64'd0);
      chk({tag, "_dbv"},       64'(DBeatValid),   64'd0);
      chk({tag, "_committed"}, 64'(BusCommitted), 64'd0);
   endtask

   // Entered in the first cycle the grant is visible; BusReady is held high for nbeats cycles.
   task automatic burst(input bit is_d, input bit wr, input logic [PA_BITS-1:0] base,
                        input int nbeats, input int drop_after, input logic [1:0] next_rw);
      for (int b = 0; b < nbeats; b++) begin
         BusReady = 1'b1;
         #1;
         chk("busreq",    64'(BusReq),       64'd1);
         chk("buswrite",  64'(BusWrite),     64'(wr));
         chk("busadr",    64'(BusAdr),       64'(base) + 64'(8 * b));
         chk("beatcount", 64'(BeatCount),    64'(b));
         chk("committed", 64'(BusCommitted), 64'(b > 0));
         chk("iack",      64'(ICacheBusAck), 64'(!is_d && b == 7));
         chk("dack",      64'(DCacheBusAck), 64'(is_d && b == 7));
         chk("ibv",       64'(IBeatValid),   64'(!is_d && !wr));
         chk("dbv",       64'(DBeatValid),   64'(is_d));
         if (b == drop_after) set_rw(is_d, 2'b00);
         if (b == 7) set_rw(is_d, next_rw);
         tick();
      end
      BusReady = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      ICacheBusRW  = 2'b00;
      DCacheBusRW  = 2'b00;
      ICacheBusAdr = '0;
      DCacheBusAdr = '0;
      BusReady     = 1'b0;
      tick();
      tick();
      chk_idle("rst");
      reset = 1'b0;
      tick();
      chk_idle("post_rst");

      // Single I$ fetch at 0x1000
      ICacheBusAdr = 34'h1000;
      ICacheBusRW  = 2'b10;
      tick();
      burst(1'b0, 1'b0, 34'h1000, 8, -1, 2'b00);
      chk_idle("t1_end");

      // Simultaneous fetches out of reset: D$ first, I$ granted at ack+2
      pulse_reset();
      ICacheBusAdr = 34'h1000;
      DCacheBusAdr = 34'h8000;
      ICacheBusRW  = 2'b10;
      DCacheBusRW  = 2'b10;
      tick();
      burst(1'b1, 1'b0, 34'h8000, 8, -1, 2'b00);
      chk("t2_gap_busreq", 64'(BusReq), 64'd0);
      tick();
      burst(1'b0, 1'b0, 34'h1000, 8, -1, 2'b00);
      chk_idle("t2_end");

      // D$ writeback then fetch with I$ pending: D-write, I-fetch, D-fetch
      DCacheBusAdr = 34'h2040;
      ICacheBusAdr = 34'h3000;
      DCacheBusRW  = 2'b01;
      ICacheBusRW  = 2'b10;
      tick();
      burst(1'b1, 1'b1, 34'h2040, 8, -1, 2'b10);
      chk("t3_gap1_busreq", 64'(BusReq), 64'd0);
      tick();
      burst(1'b0, 1'b0, 34'h3000, 8, -1, 2'b00);
      chk("t3_gap2_busreq", 64'(BusReq), 64'd0);
      tick();
      burst(1'b1, 1'b0, 34'h2040, 8, -1, 2'b00);
      chk_idle("t3_end");

      // Abort before the first beat, then a tie still goes to D$
      pulse_reset();
      DCacheBusAdr = 34'h4000;
      DCacheBusRW  = 2'b10;
      tick();
      chk("t4_busreq",    64'(BusReq),       64'd1);
      chk("t4_busadr",    64'(BusAdr),       64'h4000);
      chk("t4_committed", 64'(BusCommitted), 64'd0);
      DCacheBusRW = 2'b00;
      #1;
      chk("t4_abort_dack", 64'(DCacheBusAck), 64'd0);
      tick();
      chk_idle("t4_abort");
      ICacheBusAdr = 34'h1000;
      ICacheBusRW  = 2'b10;
      DCacheBusRW  = 2'b10;
      tick();
      burst(1'b1, 1'b0, 34'h4000, 8, -1, 2'b00);
      chk("t4_gap_busreq", 64'(BusReq), 64'd0);
      tick();
      burst(1'b0, 1'b0, 34'h1000, 8, -1, 2'b00);
      chk_idle("t4_end");

      // D$ drops RW after beat 2: burst still completes with ack
      DCacheBusAdr = 34'h5000;
      DCacheBusRW  = 2'b10;
      tick();
      burst(1'b1, 1'b0, 34'h5000, 8, 2, 2'b00);
      chk_idle("t5_end");

      // Reset at beat 4 of an I$ burst, then a clean restart
      ICacheBusAdr = 34'h6000;
      ICacheBusRW  = 2'b10;
      tick();
      burst(1'b0, 1'b0, 34'h6000, 4, -1, 2'b10);
      BusReady = 1'b1;
      reset    = 1'b1;
      #1;
      chk("t6_beat4",    64'(BeatCount),    64'd4);
      chk("t6_beat4_iack", 64'(ICacheBusAck), 64'd0);
      tick();
      BusReady = 1'b0;
      #1;
      chk_idle("t6_rst");
      reset = 1'b0;
      tick();
      burst(1'b0, 1'b0, 34'h6000, 8, -1, 2'b00);
      chk_idle("t6_end");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
